// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, addresses the combinational ROM and registers
// the returned word into the instruction register. It also handles redirects and stalls.
module instruction_fetch_unit #(
  parameter int                     ADDR_WIDTH   = 16,
  parameter int                     INSTR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  address,
  input  logic [INSTR_WIDTH-1:0] rom_instruction,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   instruction_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [INSTR_WIDTH-1:0]  ir_q;
  logic [ADDR_WIDTH-1:0]   ir_pc_q;
  logic                    valid_q;

  // NOTE: every register below is written with <= so all of them update together
  // from the values present before the edge; = here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc_q    <= RESET_VECTOR;
      ir_q    <= BUBBLE_INSTR;
      ir_pc_q <= RESET_VECTOR;
      valid_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN, STALL: begin
          if (branch_taken) begin
            // A redirect comes from a later stage, so it overrides a stall and
            // turns the word fetched this cycle into a bubble.
            state   <= RUN;
            pc_q    <= branch_target;
            ir_q    <= BUBBLE_INSTR;
            ir_pc_q <= pc_q;
            valid_q <= 1'b0;
          end else if (stall) begin
            state <= STALL;
          end else begin
            state   <= RUN;
            pc_q    <= pc_q + ADDR_WIDTH'(1);
            ir_q    <= rom_instruction;
            ir_pc_q <= pc_q;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // The ROM address comes straight from the PC register, never from the redirect inputs.
  assign address           = pc_q;
  assign instruction       = ir_q;
  assign pc                = ir_pc_q;
  assign instruction_valid = valid_q;

endmodule
